cnn_conv_acc: RTL

Accumulate/requantise stage directly downstream of the conv2 product multiplier (14-bit signed activation × 10-bit signed weight → 24-bit signed product). It sums TAPS consecutive products plus a per-output-channel bias, rounds and shifts back to the 14-bit activation format, saturates, optionally applies ReLU, and presents one output activation per window over a valid/ready handshake. It sits between the multiplier and the pooling/line-buffer stage.

---
 rtl/cnn_conv_acc_pkg.sv | 14 +
 rtl/cnn_conv_acc_if.sv | 24 ++
 rtl/cnn_conv_acc_sat.sv | 34 +++
 rtl/cnn_conv_acc.sv | 72 +++++++
 4 files changed

// File: rtl/cnn_conv_acc_pkg.sv
// Shared types and constants for the conv accumulate/requantise stages.
// Widths here are the defaults for conv2 (24b products, 14b activations).
package cnn_conv_acc_pkg;
  localparam int PROD_W = 24;
  localparam int OUT_W  = 14;
  localparam int ACC_W  = 32;

  typedef enum logic {ACC, HOLD} state_t;

  // Half an LSB at activation scale, used for round-half-up.
  function automatic logic signed [ACC_W-1:0] rnd_half(input int fs);
    return {{(ACC_W-1){1'b0}}, 1'b1} << (fs - 1);
  endfunction
endpackage

// File: rtl/cnn_conv_acc_if.sv
// Product-in / activation-out stream bundle for the conv accumulate stage.
interface cnn_conv_acc_if #(
  parameter int PW = cnn_conv_acc_pkg::PROD_W,
  parameter int OW = cnn_conv_acc_pkg::OUT_W
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_data;
  logic                 in_last;
  logic signed [OW-1:0] bias_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 tap_err;

  modport slave (
    input  in_valid, in_data, in_last, bias_data, out_ready,
    output in_ready, out_valid, out_data, tap_err
  );
  modport master (
    output in_valid, in_data, in_last, bias_data, out_ready,
    input  in_ready, out_valid, out_data, tap_err
  );
endinterface

// File: rtl/cnn_conv_acc_sat.sv
// Round-half-up, arithmetic shift and saturate from accumulator to activation width.
// Optional ReLU clamp when CNN_CONV_ACC_RELU_EN is defined.
module cnn_conv_acc_sat
  import cnn_conv_acc_pkg::*;
#(
  parameter int AW         = ACC_W,
  parameter int OW         = OUT_W,
  parameter int FRAC_SHIFT = 8
) (
  input  logic signed [AW-1:0] i_sum,
  output logic signed [OW-1:0] o_data
);
  localparam logic signed [AW-1:0] HALF = AW'(rnd_half(FRAC_SHIFT));
  localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic signed [AW-1:0] w_rnd, w_shr;
  logic signed [OW-1:0] w_sat;

  assign w_rnd = i_sum + HALF;
  assign w_shr = w_rnd >>> FRAC_SHIFT;

  always_comb begin
    w_sat = w_shr[OW-1:0];
    if (w_shr > MAXV)      w_sat = MAXV[OW-1:0];
    else if (w_shr < MINV) w_sat = MINV[OW-1:0];
  end

`ifdef CNN_CONV_ACC_RELU_EN
  assign o_data = w_sat[OW-1] ? '0 : w_sat;
`else
  assign o_data = w_sat;
`endif
endmodule

// File: rtl/cnn_conv_acc.sv
// conv2 accumulate/requantise: sums TAPS products plus bias, emits one activation per window.
// ReLU on the output is enabled by defining CNN_CONV_ACC_RELU_EN.
module cnn_conv_acc #(
  parameter int PROD_W     = cnn_conv_acc_pkg::PROD_W,
  parameter int OUT_W      = cnn_conv_acc_pkg::OUT_W,
  parameter int ACC_W      = cnn_conv_acc_pkg::ACC_W,
  parameter int TAPS       = 54,
  parameter int FRAC_SHIFT = 8
) (
  input logic            ap_clk,
  input logic            ap_rst_n,
  cnn_conv_acc_if.slave  s
);
  import cnn_conv_acc_pkg::*;

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t                   r_state, w_next;
  logic [CNT_W-1:0]         r_tap_cnt;
  logic signed [ACC_W-1:0]  r_acc, w_base, w_sum, w_in_ext, w_bias_sh;
  logic signed [OUT_W-1:0]  r_out, w_sat;
  logic                     r_run, r_err, w_accept, w_first, w_final;

  assign w_first   = (r_tap_cnt == '0);
  assign w_final   = (r_tap_cnt == CNT_W'(TAPS - 1));
  assign w_in_ext  = {{(ACC_W-PROD_W){s.in_data[PROD_W-1]}}, s.in_data};
  assign w_bias_sh = {{(ACC_W-OUT_W){s.bias_data[OUT_W-1]}}, s.bias_data} <<< FRAC_SHIFT;
  assign w_base    = w_first ? w_bias_sh : r_acc;
  assign w_sum     = w_base + w_in_ext;

  // r_run keeps in_ready low throughout reset and drops it again on re-entry.
  assign s.in_ready  = r_run && ((r_state == ACC) || s.out_ready);
  assign w_accept    = s.in_valid && s.in_ready;
  assign s.out_valid = (r_state == HOLD);
  assign s.out_data  = r_out;
  assign s.tap_err   = r_err;

  cnn_conv_acc_sat #(.AW(ACC_W), .OW(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_sat (
    .i_sum  (w_sum),
    .o_data (w_sat)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACC:  if (w_accept && w_final) w_next = HOLD;
      // A final tap taken while draining (TAPS==1) immediately refills HOLD.
      HOLD: if (s.out_ready) w_next = (w_accept && w_final) ? HOLD : ACC;
      default: w_next = ACC;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= ACC;
      r_tap_cnt <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_err     <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      if (w_accept) begin
        r_acc     <= w_sum;
        r_tap_cnt <= w_final ? '0 : r_tap_cnt + 1'b1;
        if (w_final) r_out <= w_sat;
        if (s.in_last != w_final) r_err <= 1'b1;
      end
    end
  end
endmodule
